// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 2-wide I-cache requests, instruction buffer, flush/redirect.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int unsigned CPU_ADDR_BITS = 32,
    parameter int unsigned CPU_INST_BITS = 32,
    parameter int unsigned FETCH_WIDTH   = 2,
    parameter int unsigned IB_DEPTH      = 4,
    parameter logic [CPU_ADDR_BITS-1:0] PC_RESET = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [2:0]                           pc_sel,
    input  logic [CPU_ADDR_BITS-1:0]             rob_pc,
    output logic [CPU_ADDR_BITS-1:0]             icache_addr,
    output logic                                 icache_re,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_dout,
    input  logic                                 icache_dout_val,
    input  logic                                 icache_stall,
    input  logic                                 decoder_rdy,
    output logic [CPU_ADDR_BITS-1:0]             inst0_pc,
    output logic [CPU_ADDR_BITS-1:0]             inst1_pc,
    output logic [CPU_INST_BITS-1:0]             inst0,
    output logic [CPU_INST_BITS-1:0]             inst1,
    output logic                                 inst_val
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                          perf_fetch_cnt,
    output logic [31:0]                          perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W  = (IB_DEPTH > 1) ? $clog2(IB_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PAIR_W = FETCH_WIDTH * CPU_INST_BITS;
    localparam logic [CNT_W:0] DEPTH_C = IB_DEPTH[CNT_W:0];

    logic [CPU_ADDR_BITS-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic                     inflight_q, inflight_d, drop_q, drop_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PAIR_W-1:0]        ib_inst_q [IB_DEPTH];
    logic [CPU_ADDR_BITS-1:0] ib_pc_q   [IB_DEPTH];
    logic                     empty, push, pop;
    logic [CNT_W:0]           credit_used;
    logic                     unused_pc_sel;

    assign unused_pc_sel = ^pc_sel[2:1];

    // In-flight request reserves its IB slot, so a response can always be written.
    assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign empty       = (count_q == '0);
    assign icache_addr = pc_q;
    assign icache_re   = !flush && !pc_sel[0] && !icache_stall && (credit_used < DEPTH_C);
    assign push        = icache_dout_val && !drop_q && !flush;
    assign pop         = !empty && decoder_rdy && !flush;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = icache_re;
        drop_d     = flush && inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (flush || pc_sel[0]) begin
            if (pc_sel[0]) pc_d = rob_pc;
        end else if (icache_re) begin
            pc_d     = pc_q + CPU_ADDR_BITS'(8);
            req_pc_d = pc_q;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= PC_RESET;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: buffer storage is not reset; the count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            ib_inst_q[wr_ptr_q] <= icache_dout;
            ib_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    always_comb begin
        inst_val = !empty;
        inst0    = '0;
        inst1    = '0;
        inst0_pc = '0;
        inst1_pc = '0;
        if (!empty) begin
            inst0    = ib_inst_q[rd_ptr_q][CPU_INST_BITS-1:0];
            inst1    = ib_inst_q[rd_ptr_q][2*CPU_INST_BITS-1:CPU_INST_BITS];
            inst0_pc = ib_pc_q[rd_ptr_q];
            inst1_pc = ib_pc_q[rd_ptr_q] + CPU_ADDR_BITS'(4);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (icache_re && (fetch_cnt_q != '1))
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        if ((!inst_val || !decoder_rdy) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle registered I-cache model.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  pc_sel;
    logic [31:0] rob_pc;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [63:0] icache_dout;
    logic        icache_dout_val;
    logic        icache_stall;
    logic        decoder_rdy;
    logic [31:0] inst0_pc, inst1_pc, inst0, inst1;
    logic        inst_val;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .pc_sel          (pc_sel),
        .rob_pc          (rob_pc),
        .icache_addr     (icache_addr),
        .icache_re       (icache_re),
        .icache_dout     (icache_dout),
        .icache_dout_val (icache_dout_val),
        .icache_stall    (icache_stall),
        .decoder_rdy     (decoder_rdy),
        .inst0_pc        (inst0_pc),
        .inst1_pc        (inst1_pc),
        .inst0           (inst0),
        .inst1           (inst1),
        .inst_val        (inst_val)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory word at byte address a holds a + 0x1000_0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            icache_dout_val <= 1'b0;
            icache_dout     <= '0;
        end else begin
            icache_dout_val <= icache_re;
            icache_dout     <= {mem_word(icache_addr + 32'd4), mem_word(icache_addr)};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_val"},  {31'd0, inst_val}, 32'd1);
        check({tag, "_pc0"},  inst0_pc, pc);
        check({tag, "_pc1"},  inst1_pc, pc + 32'd4);
        check({tag, "_i0"},   inst0, mem_word(pc));
        check({tag, "_i1"},   inst1, mem_word(pc + 32'd4));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_val"}, {31'd0, inst_val}, 32'd0);
        check({tag, "_pc0"}, inst0_pc, 32'd0);
        check({tag, "_i0"},  inst0, 32'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; pc_sel = 3'b000; rob_pc = '0;
        icache_stall = 1'b0; decoder_rdy = 1'b1;
        #2;
        check_empty("reset");
        check("reset_addr", icache_addr, 32'd0);
        check("reset_pc1", inst1_pc, 32'd0);
        tick(); tick();
        rst = 1'b1; #1;
        check("boot_addr", icache_addr, 32'd0);
        check("boot_re", {31'd0, icache_re}, 32'd1);

        tick(); // first request accepted
        check("lat_val", {31'd0, inst_val}, 32'd0);
        check("lat_addr", icache_addr, 32'd8);
        tick();
        check_head("first", 32'd0);

        for (int k = 3; k <= 5; k++) begin
            tick();
            check_head("seq", 32'(8 * (k - 2)));
        end

        // Decoder stall: head frozen at 24 while the buffer fills up.
        decoder_rdy = 1'b0;
        tick();
        check_head("dstall1", 32'd24);
        check("dstall1_re", {31'd0, icache_re}, 32'd1);
        tick();
        check_head("dstall2", 32'd24);
        check("dstall2_re", {31'd0, icache_re}, 32'd0);
        tick();
        check_head("dstall3", 32'd24);
        check("dstall3_re", {31'd0, icache_re}, 32'd0);
        decoder_rdy = 1'b1;
        for (int k = 9; k <= 12; k++) begin
            tick();
            check_head("resume", 32'(32 + 8 * (k - 9)));
        end

        // I-cache stall: address held, buffer drains.
        icache_stall = 1'b1; #1;
        check("cstall_re", {31'd0, icache_re}, 32'd0);
        check("cstall_addr", icache_addr, 32'd80);
        tick();
        check_head("cstall1", 32'd64);
        tick();
        check_head("cstall2", 32'd72);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_empty("drained");
            check("drained_addr", icache_addr, 32'd80);
            check("drained_re", {31'd0, icache_re}, 32'd0);
        end
        icache_stall = 1'b0; #1;
        check("cresume_re", {31'd0, icache_re}, 32'd1);
        check("cresume_addr", icache_addr, 32'd80);
        tick();
        check("cresume_lat", {31'd0, inst_val}, 32'd0);
        tick();
        check_head("cresume", 32'd80);

        // Redirect to 4 with a request (88) in flight.
        flush = 1'b1; pc_sel = 3'b001; rob_pc = 32'd4; #1;
        check("flush_re", {31'd0, icache_re}, 32'd0);
        tick();
        check_empty("flushed");
        flush = 1'b0; pc_sel = 3'b000; #1;
        check("redir_addr", icache_addr, 32'd4);
        check("redir_re", {31'd0, icache_re}, 32'd1);
        tick();
        check_empty("redir_lat");
        tick();
        check_head("redir", 32'd4);
        tick();
        check_head("redir2", 32'd12);

        // Asynchronous reset between edges.
        #1 rst = 1'b0;
        #1;
        check_empty("areset");
        check("areset_addr", icache_addr, 32'd0);
        tick();
        rst = 1'b1; #1;
        check("restart_addr", icache_addr, 32'd0);
        check("restart_re", {31'd0, icache_re}, 32'd1);
        tick();
        check("restart_lat", {31'd0, inst_val}, 32'd0);
        tick();
        check_head("restart", 32'd0);
        tick();
        check_head("restart2", 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end instruction fetch stage of the out-of-order RISC-V core.
- Holds the PC and issues aligned 2-wide fetch requests to the I-cache/memory model (1-cycle registered response).
- Queues returned instruction pairs in an internal instruction buffer (IB) and presents one pair per cycle to the decoder.
- Redirects on ROB flush.

Parameters:
- CPU_ADDR_BITS, 32, address/PC width
- CPU_INST_BITS, 32, instruction width
- FETCH_WIDTH, 2, instructions per fetch (fixed at 2)
- IB_DEPTH, 4, instruction-buffer entries (each entry = 2 insts + base PC), power of 2
- PC_RESET, 32'h0000_0000, reset vector

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush from ROB
- pc_sel  in  3  PC source select; [0]=ROB redirect, [2:1] reserved/ignored
- rob_pc  in  CPU_ADDR_BITS  redirect target
- icache_addr  out  CPU_ADDR_BITS  fetch address (= PC)
- icache_re  out  1  fetch request valid
- icache_dout  in  FETCH_WIDTH*CPU_INST_BITS  [31:0]=inst @addr, [63:32]=inst @addr+4
- icache_dout_val  in  1  response valid, one cycle after accepted request
- icache_stall  in  1  cache cannot accept a request this cycle
- decoder_rdy  in  1  decoder accepts the pair this cycle
- inst0_pc  out  CPU_ADDR_BITS  PC of inst0
- inst1_pc  out  CPU_ADDR_BITS  inst0_pc+4
- inst0  out  CPU_INST_BITS  first instruction
- inst1  out  CPU_INST_BITS  second instruction
- inst_val  out  1  output pair valid

Behaviour:
- Reset (rst=0, async): PC=PC_RESET; IB empty; in-flight flag clear; drop flag clear; inst_val=0; inst*/inst*_pc=0.
- Request accepted when icache_re=1 and icache_stall=0.
- icache_re = !flush && !icache_stall && (IB count + in-flight) < IB_DEPTH. The credit rule guarantees every response has a slot.
- icache_addr is always PC (combinational); held while stalled.
- On an accepted request: PC <= PC+8 (wraps modulo 2^CPU_ADDR_BITS); in-flight flag set for next cycle.
- Response: on a clk edge with icache_dout_val=1 and drop flag clear, push {icache_dout, base PC of that request} into the IB. The base PC is captured in a register at request time.
- Output is combinational from the IB head:
  - inst_val = !empty.
  - inst0/inst1 = head halves; inst0_pc = head PC; inst1_pc = head PC+4.
  - Empty IB drives 0 on data/PC outputs.
- Pop on inst_val && decoder_rdy. Push and pop in the same cycle are both honoured; count unchanged.
- decoder_rdy=0: head held stable; fetch continues until credit is exhausted, then icache_re=0.
- Latency: request edge N -> response valid after N -> IB write at edge N+1 -> visible on outputs after N+1.
- Flush (flush=1 at edge):
  - IB cleared (empty), pointers reset.
  - If pc_sel[0]=1, PC <= rob_pc; else PC unchanged.
  - No request issued in the flush cycle.
  - If a request was in flight, set drop flag so the next response is discarded; drop flag clears after one cycle.
- Flush has priority over push, pop and PC increment.
- pc_sel[0] without flush: PC <= rob_pc; IB not cleared; no request that cycle.
- inst_val never asserts for instructions fetched before a flush.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (accepted requests) and perf_stall_cnt[31:0] (cycles with inst_val=0 or decoder_rdy=0).
  - Both counters cleared by reset and saturate at all-ones.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset release, mem holding words 0..N: edge 1 icache_addr=0 with re=1; inst_val=1 after edge 2 with inst0_pc=0, inst1_pc=4, insts = mem[0], mem[1].
- Sequential: rdy=1 steady -> inst0_pc increments 0,8,16,... every cycle; inst1_pc=inst0_pc+4; no gaps after warm-up.
- Decoder stall 3 cycles (rdy=0): outputs frozen; icache_re drops once count+in-flight=IB_DEPTH; on release pairs resume with no loss or duplicates.
- I-cache stall 5 cycles: icache_re=0, icache_addr held; IB drains (inst_val falls to 0 once empty); resumes at held PC after release.
- Redirect: flush=1, pc_sel=3'b001, rob_pc=4 for one edge -> IB empty; two edges later inst0_pc=4, inst1_pc=8; stale in-flight response never appears.
- Async reset mid-stream: rst low between edges -> inst_val=0 and PC=PC_RESET immediately; fetch restarts from PC_RESET.
